serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  Serial frame transmitter: accepts a parallel DATA_W-bit word over a valid/ready handshake and
//  emits it as a bit stream, one bit per clk: sync preamble, payload MSB-first, then idle gap.
//  Bit-serial generator side of our serial sequence-detector FSMs.
//  The default preamble 3'b101 is the pattern those detectors flag.
//  Moore-style: every output is a registered function of state and counters only.
// PARAMETERS
//  DATA_W      8       payload width in bits (>=1)
//  PRE_LEN     3       preamble length in bits (>=1)
//  PREAMBLE    3'b101  preamble pattern [PRE_LEN-1:0], sent MSB first
//  GAP_CYCLES  2       idle cycles after payload before next accept (>=0)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       upstream word valid
//  in_data    in   DATA_W  word to transmit
//  in_ready   out  1       block can accept a word (high only in IDLE)
//  dout       out  1       serial bit stream
//  dout_valid out  1       dout carries a preamble or payload bit
//  busy       out  1       frame in progress (PREAMBLE, DATA or GAP)
//  done       out  1       one-cycle pulse coincident with last payload bit
// BEHAVIOUR
//  Reset values: in_ready=1, dout=0, dout_valid=0, busy=0, done=0. State=IDLE. Shift reg and counter=0.
//  States:
//   IDLE      -> PREAMBLE on in_valid&&in_ready; in_data latched into shift register
//   PREAMBLE  PRE_LEN cycles; dout=PREAMBLE[PRE_LEN-1-k]; then -> DATA
//   DATA      DATA_W cycles; dout=shift_reg MSB, shift left each cycle
//             -> GAP if GAP_CYCLES>0, else -> IDLE
//   GAP       GAP_CYCLES cycles; then -> IDLE
//  Timing: handshake sampled at edge N.
//   Preamble on edges N+1..N+PRE_LEN; payload on the following DATA_W edges.
//   Gap follows; in_ready returns high after PRE_LEN+DATA_W+GAP_CYCLES cycles.
//  Output decode:
//   dout_valid=1 in PREAMBLE and DATA only.
//   dout=0 whenever dout_valid=0 (IDLE, GAP).
//   busy = (state!=IDLE); in_ready = (state==IDLE).
//  done=1 exactly on the cycle the payload LSB is on dout.
//  Handshake: in_valid while in_ready=0 is ignored; the word is not queued.
//   in_data is sampled only at the accept edge; later changes to in_data do not affect the frame.
//   in_valid may be held high: the next word is accepted on the first IDLE cycle, giving back-to-back frames.
//  Reset mid-frame: the frame is abandoned.
//   The next cycle shows IDLE reset values; no done pulse; the latched word is discarded.
//  Counter: single down-counter, width $clog2(max(PRE_LEN,DATA_W,GAP_CYCLES)+1).
//   Reloaded on every state entry; the state exits when the count reaches 1.
//  GAP_CYCLES=0: DATA -> IDLE directly; GAP is never entered.
// STRUCTURE
//  Shared package/include: state encodings (IDLE/PREAMBLE/DATA/GAP, 2 bits), CNT_W function.
//   Shared with the detector FSMs so the frame format is defined once.
//  One sub-module: frame_bit_counter (loadable down-counter with load value, dec, zero/one flags).
//  Top level: state register, shift register, next-state logic, registered output decode.
// TESTING
//  1. Defaults, rst 2 cycles, in_data=8'hA5 accepted at edge 0
//     -> dout 1,0,1 | 1,0,1,0,0,1,0,1 on edges 1-11; done only at edge 11; in_ready=1 at edge 14.
//  2. in_valid held high, words 8'hFF then 8'h00
//     -> second preamble starts 1 cycle after in_ready rises; the gap is exactly 2 cycles of dout=0, dout_valid=0.
//  3. in_valid pulsed and in_data changed during DATA
//     -> transmitted bits are unchanged; no extra accept; in_ready stays 0 until IDLE.
//  4. rst asserted on edge 6 (mid-payload)
//     -> edge 7: dout=0, dout_valid=0, busy=0, in_ready=1; done never pulses for that frame.
//  5. GAP_CYCLES=0, DATA_W=4, PRE_LEN=1, PREAMBLE=1'b1, in_data=4'h9
//     -> dout 1|1,0,0,1; in_ready=1 on the cycle after done.
//  6. Loopback into the 101 Moore detector
//     -> detector output pulses at least once per frame, aligned to the preamble end.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// serial_pattern_tx_pkg: frame state encoding and counter sizing shared with the detector FSMs
package serial_pattern_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} frame_state_t;
  function automatic int cnt_w(input int pre_len, input int data_w, input int gap);
    int m;
    m = pre_len > data_w ? pre_len : data_w;
    m = gap > m ? gap : m;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/serial_pattern_tx_counter.sv
// frame_bit_counter: loadable down-counter with look-ahead value and zero/one flags
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt_next,
  output logic         zero,
  output logic         one
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  assign one = cnt == W'(1);
  assign cnt_next = load ? load_val : (dec && !zero) ? cnt - W'(1) : cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= cnt_next;
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a word as preamble + MSB-first payload + idle gap, one bit per clock
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRE_LEN = 3,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 3'b101,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = cnt_w(PRE_LEN, DATA_W, GAP_CYCLES);
  frame_state_t state, state_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic [CNT_W-1:0] load_val, cnt_n;
  logic load, dec, c_zero, c_one;
  logic [PRE_LEN-1:0] pre_sh;
  frame_bit_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec(dec),
    .cnt_next(cnt_n), .zero(c_zero), .one(c_one)
  );
  always_comb begin
    state_n = state;
    sr_n = sr;
    load = 1'b0;
    load_val = '0;
    dec = 1'b0;
    case (state)
      S_IDLE: if (in_valid && in_ready) begin
        state_n = S_PRE;
        sr_n = in_data;
        load = 1'b1;
        load_val = CNT_W'(PRE_LEN);
      end
      S_PRE: if (c_one) begin
        state_n = S_DATA;
        load = 1'b1;
        load_val = CNT_W'(DATA_W);
      end else dec = 1'b1;
      S_DATA: begin
        sr_n = sr << 1;
        if (c_one) begin
          state_n = GAP_CYCLES > 0 ? S_GAP : S_IDLE;
          load = 1'b1;
          load_val = CNT_W'(GAP_CYCLES);
        end else dec = 1'b1;
      end
      default: if (c_one || c_zero) begin
        state_n = S_IDLE;
        load = 1'b1;
      end else dec = 1'b1;
    endcase
  end
  // outputs are decoded from the upcoming state so they line up with the state just entered
  assign pre_sh = PREAMBLE >> (cnt_n - CNT_W'(1));
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      sr <= '0;
      in_ready <= 1'b1;
      dout <= 1'b0;
      dout_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      in_ready <= state_n == S_IDLE;
      busy <= state_n != S_IDLE;
      dout_valid <= state_n == S_PRE || state_n == S_DATA;
      dout <= state_n == S_PRE ? pre_sh[0] : state_n == S_DATA ? sr_n[DATA_W-1] : 1'b0;
      done <= state_n == S_DATA && cnt_n == CNT_W'(1);
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: frame-level reference model checks for serial_pattern_tx
module tb_serial_pattern_tx;
  localparam int PRE = 3, DW = 8, GAP = 2, L = PRE + DW + GAP;
  localparam logic [2:0] PAT = 3'b101;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, dout, dout_valid, busy, done;
  logic [7:0] in_data = '0;
  logic in_valid5 = 1'b0, in_ready5, dout5, dout_valid5, busy5, done5;
  logic [3:0] in_data5 = '0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  serial_pattern_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );
  serial_pattern_tx #(.DATA_W(4), .PRE_LEN(1), .PREAMBLE(1'b1), .GAP_CYCLES(0)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .dout(dout5), .dout_valid(dout_valid5), .busy(busy5), .done(done5)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " dout_valid"}, 32'(dout_valid), 0);
    chk({tag, " dout"}, 32'(dout), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask
  // mode 0: in_valid dropped after accept, 1: random in_valid/in_data noise, 2: in_valid held high
  task automatic frame(input logic [7:0] w, input int mode);
    logic [10:0] fb;
    logic [2:0] hist;
    fb = {PAT, w};
    hist = '0;
    in_valid = 1'b1;
    in_data = w;
    @(negedge clk);
    for (int j = 0; j < L; j++) begin
      chk("dout", 32'(dout), j < PRE + DW ? 32'(fb[10-j]) : 0);
      chk("dout_valid", 32'(dout_valid), 32'(j < PRE + DW));
      chk("done", 32'(done), 32'(j == PRE + DW - 1));
      chk("busy", 32'(busy), 1);
      chk("in_ready", 32'(in_ready), 0);
      if (dout_valid) hist = {hist[1:0], dout};
      if (j == PRE - 1) chk("detect101", 32'(hist == 3'b101), 1);
      in_valid = mode == 2 ? 1'b1 : mode == 1 ? 1'($urandom) : 1'b0;
      if (mode == 1) in_data = 8'($urandom);
      if (j == L - 1) in_valid = mode == 2;
      @(negedge clk);
    end
    chk_idle("frame end");
  endtask
  initial begin
    logic [7:0] w;
    logic [4:0] f5;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset in_ready5", 32'(in_ready5), 1);
    chk("reset dout_valid5", 32'(dout_valid5), 0);
    rst = 1'b0;
    @(negedge clk);
    frame(8'hA5, 0);
    frame(8'hFF, 2);
    frame(8'h00, 0);
    frame(8'h3C, 1);
    for (int k = 0; k < 6; k++) frame(8'($urandom), int'($urandom_range(0, 2)));
    frame(8'h5A, 0);
    w = 8'hC3;
    in_valid = 1'b1;
    in_data = w;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      chk("pre-reset dout", 32'(dout), 32'(j < PRE ? PAT[2-j] : w[DW-1-(j-PRE)]));
      in_valid = 1'b0;
      if (j == 5) rst = 1'b1;
      @(negedge clk);
    end
    chk_idle("mid-frame reset");
    rst = 1'b0;
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      chk("after reset done", 32'(done), 0);
      chk("after reset busy", 32'(busy), 0);
    end
    frame(8'h81, 0);
    f5 = 5'b1_1001;
    in_valid5 = 1'b1;
    in_data5 = 4'h9;
    @(negedge clk);
    in_valid5 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("g0 dout", 32'(dout5), 32'(f5[4-j]));
      chk("g0 dout_valid", 32'(dout_valid5), 1);
      chk("g0 done", 32'(done5), 32'(j == 4));
      chk("g0 in_ready", 32'(in_ready5), 0);
      @(negedge clk);
    end
    chk("g0 in_ready after done", 32'(in_ready5), 1);
    chk("g0 busy after done", 32'(busy5), 0);
    chk("g0 dout_valid after done", 32'(dout_valid5), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
